// File: rtl/button_events_pkg.sv
// Shared definitions for the button gesture classifier: event codes carried
// on the front-panel event slot and the classifier FSM state encoding.
// Other front-panel event producers import the event codes from here.
package button_events_pkg;

  localparam int EV_W = 2;

  localparam logic [EV_W-1:0] EV_CLICK  = 2'd0;
  localparam logic [EV_W-1:0] EV_DOUBLE = 2'd1;
  localparam logic [EV_W-1:0] EV_LONG   = 2'd2;
  localparam logic [EV_W-1:0] EV_REPEAT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOWN1 = 3'd1,
    ST_WAIT2 = 3'd2,
    ST_DOWN2 = 3'd3,
    ST_HELD  = 3'd4
  } state_t;

endpackage

// File: rtl/event_slot.sv
// One-entry valid/ready holding register for front-panel events.
// Latency: an accepted input appears on out_vld/out_dat the next cycle.
// Backpressure: loads when empty or draining this cycle; otherwise drops and pulses overflow next cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_vld, in_dat      event offered this cycle (no ready: producer cannot stall)
//   out_vld, out_rdy    output handshake, transfer when both high
//   out_dat             event payload, stable while out_vld is high
//   overflow            registered one-cycle pulse per dropped event
module event_slot #(
  parameter int DAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [DAT_W-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DAT_W-1:0] out_dat,
  output logic             overflow
);

  logic             vld_q, vld_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             ovf_q, ovf_d;
  logic             drain;
  logic             load;

  always_comb begin
    drain = vld_q & out_rdy;
    // A slot being drained this cycle frees up in time for a new event,
    // which gives back-to-back delivery with no bubble.
    load  = in_vld & (~vld_q | drain);
    vld_d = vld_q;
    dat_d = dat_q;
    ovf_d = in_vld & ~load;
    if (load) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (drain) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_dat  = dat_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/button_events.sv
// Gesture classifier (CLICK/DOUBLE/LONG/REPEAT) fed by debouncer press/release pulses.
// Latency: event_valid rises one cycle after the triggering pulse or timer-expiry cycle.
// Backpressure: one-entry slot; an event arriving while the slot is full is dropped with an overflow pulse.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   press                         one-cycle pulse on switch closing (debouncer trans_up)
//   release_in                    one-cycle pulse on switch opening (debouncer trans_down)
//   event_valid/event_ready       output slot handshake
//   event_code                    0 CLICK, 1 DOUBLE, 2 LONG, 3 REPEAT
//   overflow                      one-cycle pulse, one cycle after a dropped event
// Build option: define BUTTON_REPEAT_EN to emit REPEAT every REPEAT_CYCLES while held after LONG.
module button_events
  import button_events_pkg::*;
#(
  parameter int             CNT_W         = 24,
  parameter logic [CNT_W:0] LONG_CYCLES   = 25'd1_000_000,
  parameter logic [CNT_W:0] DOUBLE_CYCLES = 25'd250_000,
  parameter logic [CNT_W:0] REPEAT_CYCLES = 25'd100_000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            press,
  input  logic            release_in,
  output logic            event_valid,
  output logic [EV_W-1:0] event_code,
  input  logic            event_ready,
  output logic            overflow
);

  // Timers compare for equality against PARAM-1, so a zero value is meaningless.
  if (LONG_CYCLES == '0 || DOUBLE_CYCLES == '0 || REPEAT_CYCLES == '0) begin : g_bad_timer_param
    $error("button_events: timer parameters must be at least 1");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1'b1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 1'b1);
`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1'b1);
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              emit_vld;
  logic [EV_W-1:0]   emit_dat;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit_vld = 1'b0;
    emit_dat = EV_CLICK;
    // Simultaneous press and release is not a legal debouncer output; the
    // cycle is treated as a complete no-op rather than guessing an order.
    if (!(press && release_in)) begin
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_d = ST_DOWN1;
            cnt_d   = '0;
          end
        end
        ST_DOWN1: begin
          // Edge inputs are checked before expiry so a release on the
          // expiry cycle still counts as a short press.
          if (release_in) begin
            state_d = ST_WAIT2;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            state_d  = ST_HELD;
            cnt_d    = '0;
            emit_vld = 1'b1;
            emit_dat = EV_LONG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT2: begin
          if (press) begin
            state_d = ST_DOWN2;
            cnt_d   = '0;
          end else if (cnt_q == DOUBLE_LAST) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            emit_vld = 1'b1;
            emit_dat = EV_CLICK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DOWN2: begin
          // No timer here: a second press can only ever produce DOUBLE.
          if (release_in) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            emit_vld = 1'b1;
            emit_dat = EV_DOUBLE;
          end
        end
        ST_HELD: begin
          if (release_in) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
`ifdef BUTTON_REPEAT_EN
          else if (cnt_q == REPEAT_LAST) begin
            cnt_d    = '0;
            emit_vld = 1'b1;
            emit_dat = EV_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  event_slot #(
    .DAT_W (EV_W)
  ) u_slot (
    .clk      (CLK),
    .rst      (RST),
    .in_vld   (emit_vld),
    .in_dat   (emit_dat),
    .out_vld  (event_valid),
    .out_rdy  (event_ready),
    .out_dat  (event_code),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with LONG=20, DOUBLE=10, REPEAT=5 cycles.
// Cycle k of a scenario is the clock period whose inputs are sampled at the
// k+1-th rising edge; outputs are logged at the falling edge inside cycle k.
module tb_button_events;
  import button_events_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       press = 1'b0;
  logic       release_in = 1'b0;
  logic       event_ready = 1'b1;
  logic       event_valid;
  logic [1:0] event_code;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  localparam int NLOG = 128;
  logic       val_log  [NLOG];
  logic [1:0] code_log [NLOG];
  logic       ovf_log  [NLOG];
  logic       rdy_log  [NLOG];

  int         ev_cyc[$];
  logic [1:0] ev_code[$];
  int         ov_cyc[$];

  button_events #(
    .CNT_W         (24),
    .LONG_CYCLES   (25'd20),
    .DOUBLE_CYCLES (25'd10),
    .REPEAT_CYCLES (25'd5)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .press       (press),
    .release_in  (release_in),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_ready (event_ready),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; press = 1'b0; release_in = 1'b0; event_ready = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Drives one scenario (pulse cycles, -1 = unused), logs outputs per cycle,
  // then extracts accepted events and overflow pulses.
  task automatic drive(input int ncyc, input int pa, input int pb, input int ra,
                       input int rb, input int rdy_from, input int rst_at);
    for (int k = 0; k < ncyc; k++) begin
      val_log[k]  = event_valid;
      code_log[k] = event_code;
      ovf_log[k]  = overflow;
      rdy_log[k]  = (k >= rdy_from);
      press       = (k == pa) || (k == pb);
      release_in  = (k == ra) || (k == rb);
      event_ready = (k >= rdy_from);
      RST         = (k == rst_at);
      @(negedge CLK);
    end
    press = 1'b0; release_in = 1'b0; RST = 1'b0; event_ready = 1'b1;
    ev_cyc.delete(); ev_code.delete(); ov_cyc.delete();
    for (int k = 0; k < ncyc; k++) begin
      if (val_log[k] && rdy_log[k]) begin
        ev_cyc.push_back(k);
        ev_code.push_back(code_log[k]);
      end
      if (ovf_log[k]) ov_cyc.push_back(k);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", event_valid); end
    total++; if (event_code !== 2'd0) begin bad++; $display("FAIL reset_code: got %0d expected 0", event_code); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    total++; if (dut.cnt_q !== 24'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
    RST = 1'b0;
  endtask

  task automatic test_click();
    int         exp_cyc[$];
    logic [1:0] exp_code[$];
    exp_cyc = '{16}; exp_code = '{EV_CLICK};
    do_reset();
    drive(40, 0, -1, 5, -1, 0, -1);
    total++; if (ev_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL click_count: got %0d expected %0d", ev_cyc.size(), exp_cyc.size()); end
    foreach (exp_cyc[i]) if (i < ev_cyc.size()) begin
      total++; if (ev_cyc[i] !== exp_cyc[i] || ev_code[i] !== exp_code[i]) begin bad++; $display("FAIL click_event%0d: got cycle %0d code %0d expected cycle %0d code %0d", i, ev_cyc[i], ev_code[i], exp_cyc[i], exp_code[i]); end
    end
  endtask

  task automatic test_double();
    int         exp_cyc[$];
    logic [1:0] exp_code[$];
    exp_cyc = '{13}; exp_code = '{EV_DOUBLE};
    do_reset();
    drive(40, 0, 9, 5, 12, 0, -1);
    total++; if (ev_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL double_count: got %0d expected %0d", ev_cyc.size(), exp_cyc.size()); end
    foreach (exp_cyc[i]) if (i < ev_cyc.size()) begin
      total++; if (ev_cyc[i] !== exp_cyc[i] || ev_code[i] !== exp_code[i]) begin bad++; $display("FAIL double_event%0d: got cycle %0d code %0d expected cycle %0d code %0d", i, ev_cyc[i], ev_code[i], exp_cyc[i], exp_code[i]); end
    end
    // Second press lands on the WAIT2 expiry cycle (release@5 -> cnt hits 9 at cycle 15).
    exp_cyc = '{19}; exp_code = '{EV_DOUBLE};
    do_reset();
    drive(40, 0, 15, 5, 18, 0, -1);
    total++; if (ev_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL double_edge_count: got %0d expected %0d", ev_cyc.size(), exp_cyc.size()); end
    foreach (exp_cyc[i]) if (i < ev_cyc.size()) begin
      total++; if (ev_cyc[i] !== exp_cyc[i] || ev_code[i] !== exp_code[i]) begin bad++; $display("FAIL double_edge_event%0d: got cycle %0d code %0d expected cycle %0d code %0d", i, ev_cyc[i], ev_code[i], exp_cyc[i], exp_code[i]); end
    end
  endtask

  task automatic test_long();
    int         exp_cyc[$];
    logic [1:0] exp_code[$];
    exp_cyc = '{21}; exp_code = '{EV_LONG};
`ifdef BUTTON_REPEAT_EN
    for (int c = 26; c <= 56; c += 5) begin
      exp_cyc.push_back(c);
      exp_code.push_back(EV_REPEAT);
    end
`endif
    do_reset();
    drive(70, 0, -1, 60, -1, 0, -1);
    total++; if (ev_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL long_count: got %0d expected %0d", ev_cyc.size(), exp_cyc.size()); end
    foreach (exp_cyc[i]) if (i < ev_cyc.size()) begin
      total++; if (ev_cyc[i] !== exp_cyc[i] || ev_code[i] !== exp_code[i]) begin bad++; $display("FAIL long_event%0d: got cycle %0d code %0d expected cycle %0d code %0d", i, ev_cyc[i], ev_code[i], exp_cyc[i], exp_code[i]); end
    end
    total++; if (ov_cyc.size() !== 0) begin bad++; $display("FAIL long_overflow: got %0d pulses expected 0", ov_cyc.size()); end
  endtask

  task automatic test_edge_beats_timer();
    // release@19 and release@20 (the LONG expiry cycle) both yield a CLICK.
    int rel_at[2]   = '{19, 20};
    int click_at[2] = '{30, 31};
    for (int t = 0; t < 2; t++) begin
      do_reset();
      drive(45, 0, -1, rel_at[t], -1, 0, -1);
      total++; if (ev_cyc.size() !== 1) begin bad++; $display("FAIL edge%0d_count: got %0d expected 1", t, ev_cyc.size()); end
      if (ev_cyc.size() > 0) begin
        total++; if (ev_cyc[0] !== click_at[t] || ev_code[0] !== EV_CLICK) begin bad++; $display("FAIL edge%0d_event: got cycle %0d code %0d expected cycle %0d code 0", t, ev_cyc[0], ev_code[0], click_at[t]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int         exp_cyc[$];
    logic [1:0] exp_code[$];
    int         exp_ov;
    int         held_bad;
`ifdef BUTTON_REPEAT_EN
    // REPEAT@25 is dropped; REPEAT@30 loads while LONG drains (no bubble).
    exp_cyc = '{30, 31, 36}; exp_code = '{EV_LONG, EV_REPEAT, EV_REPEAT};
    exp_ov  = 1;
`else
    exp_cyc = '{30}; exp_code = '{EV_LONG};
    exp_ov  = 0;
`endif
    do_reset();
    drive(50, 0, -1, 40, -1, 30, -1);
    total++; if (ev_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL bp_count: got %0d expected %0d", ev_cyc.size(), exp_cyc.size()); end
    foreach (exp_cyc[i]) if (i < ev_cyc.size()) begin
      total++; if (ev_cyc[i] !== exp_cyc[i] || ev_code[i] !== exp_code[i]) begin bad++; $display("FAIL bp_event%0d: got cycle %0d code %0d expected cycle %0d code %0d", i, ev_cyc[i], ev_code[i], exp_cyc[i], exp_code[i]); end
    end
    total++; if (ov_cyc.size() !== exp_ov) begin bad++; $display("FAIL bp_overflow_count: got %0d expected %0d", ov_cyc.size(), exp_ov); end
    if (exp_ov == 1 && ov_cyc.size() == 1) begin
      total++; if (ov_cyc[0] !== 26) begin bad++; $display("FAIL bp_overflow_cycle: got %0d expected 26", ov_cyc[0]); end
    end
    held_bad = 0;
    for (int k = 21; k < 30; k++) if (val_log[k] !== 1'b1 || code_log[k] !== EV_LONG) held_bad++;
    total++; if (held_bad !== 0) begin bad++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", held_bad); end
    total++; if (val_log[20] !== 1'b0) begin bad++; $display("FAIL bp_valid_before: got %b expected 0", val_log[20]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(40, 0, -1, 12, -1, 0, 8);
    total++; if (ev_cyc.size() !== 0 || ov_cyc.size() !== 0) begin bad++; $display("FAIL rstmid_events: got %0d events %0d overflows expected 0 0", ev_cyc.size(), ov_cyc.size()); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    total++; if ({event_valid, event_code, overflow} !== 4'b0) begin bad++; $display("FAIL rstmid_outputs: got %b expected 0000", {event_valid, event_code, overflow}); end
    // A CLICK stuck in the slot (ready low) is discarded by a reset.
    do_reset();
    drive(30, 0, -1, 5, -1, 999, 20);
    total++; if (val_log[20] !== 1'b1 || code_log[20] !== EV_CLICK) begin bad++; $display("FAIL rstmid_pending: got valid %b code %0d expected valid 1 code 0", val_log[20], code_log[20]); end
    total++; if (val_log[21] !== 1'b0) begin bad++; $display("FAIL rstmid_discard: got %b expected 0", val_log[21]); end
  endtask

  task automatic test_ignored_inputs();
    // Cycle 0: press and release together (no-op); release in IDLE also ignored.
    do_reset();
    drive(35, 0, 3, 0, 8, 0, -1);
    total++; if (ev_cyc.size() !== 1) begin bad++; $display("FAIL ignore_count: got %0d expected 1", ev_cyc.size()); end
    if (ev_cyc.size() > 0) begin
      total++; if (ev_cyc[0] !== 19 || ev_code[0] !== EV_CLICK) begin bad++; $display("FAIL ignore_event: got cycle %0d code %0d expected cycle 19 code 0", ev_cyc[0], ev_code[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_click();
    test_double();
    test_long();
    test_edge_beats_timer();
    test_backpressure();
    test_reset_mid();
    test_ignored_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
